// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory LSU.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-lane data RAM with load/store front end: wait states, load extension and
// misalignment/range faults behind a valid/ready request and response handshake.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);
  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WLAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, take;

  logic        we_p0, uns_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0, wdata_p0;
  logic        fault_p0;
  logic [3:0]  be_p0;
  logic [31:0] wlane_p0;
  logic [AW-1:0] idx_p0;

  logic        vld_p1, fault_p1, we_p1, uns_p1;
  logic [1:0]  size_p1, off_p1;
  logic [31:0] word_p1;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0:    r = uns ? $signed({24'd0, b}) : b;
      2'd1:    r = uns ? $signed({16'd0, h}) : h;
      default: r = $signed(word);
    endcase
    return r;
  endfunction

  assign bus.req_ready = (state == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign take          = bus.rsp_valid && bus.rsp_ready;

  assign idx_p0   = addr_p0[AW+1:2];
  assign fault_p0 = (size_p0 == 2'd3) ||
                    ((size_p0 == 2'd1) && addr_p0[0]) ||
                    ((size_p0 == 2'd2) && (addr_p0[1:0] != 2'd0)) ||
                    ({1'b0, addr_p0} >= BYTES);

  always_comb begin
    be_p0    = 4'd0;
    wlane_p0 = wdata_p0;
    case (size_p0)
      2'd0: begin
        be_p0    = 4'b0001 << addr_p0[1:0];
        wlane_p0 = {4{wdata_p0[7:0]}};
      end
      2'd1: begin
        be_p0    = 4'b0011 << {addr_p0[1], 1'b0};
        wlane_p0 = {2{wdata_p0[15:0]}};
      end
      2'd2:    be_p0 = 4'hF;
      default: be_p0 = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
        cnt_nxt   = 4'd0;
      end
      S_WAIT: if (cnt == WLAST) begin
        state_nxt = S_EXEC;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (take) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      vld_p1        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= (state == S_EXEC);
      // p1 -> response: extension applied one cycle after the RAM access
      if (vld_p1) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= (fault_p1 || we_p1) ? 32'd0 : load_ext(word_p1, size_p1, off_p1, uns_p1);
        bus.rsp_err   <= fault_p1;
      end else if (take) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  // p0: request fields frozen at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      uns_p0   <= bus.req_unsigned;
      size_p0  <= bus.req_size;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
    if (state == S_EXEC) begin
      fault_p1 <= fault_p0;
      we_p1    <= we_p0;
      uns_p1   <= uns_p0;
      size_p1  <= size_p0;
      off_p1   <= addr_p0[1:0];
    end
  end

  // p0 -> p1: RAM access in EXEC; reset in the same cycle suppresses the write
  always_ff @(posedge clk) begin
    if (state == S_EXEC) begin
      word_p1 <= mem[idx_p0];
      if (!rst && we_p0 && !fault_p0) begin
        for (int i = 0; i < 4; i++) begin
          if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wlane_p0[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Randomised bench for dmem_lsu against a byte-array reference model of the memory.
module tb_dmem_lsu;
  localparam int DEPTH = 256;
  localparam int WAITC = 3;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [7:0] mem_m [BYTES];

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: fault rules, then little-endian byte array read/modify.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
    int nb;
    logic [31:0] v;
    err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(BYTES));
    rdata = 32'd0;
    if (err) return;
    nb = 1 << size;
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[int'(addr) + i]) << (8 * i));
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      rdata = v;
    end
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rdata);
      chk("hold_err", 32'(bus.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_taken", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] er, gr;
    logic ee, ge;
    int lat;
    model(we, size, uns, addr, wdata, er, ee);
    access(we, size, uns, addr, wdata, hold, gr, ge, lat);
    chk({tag, "_rdata"}, gr, er);
    chk({tag, "_err"}, 32'(ge), 32'(ee));
    chk({tag, "_latency"}, 32'(lat), 32'(WAITC + 2));
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

    for (int w = 0; w < DEPTH; w++) run_op("fill", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0);

    run_op("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00F0, 0);
    run_op("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    run_op("sb13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB, 0);
    run_op("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    run_op("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    run_op("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    run_op("sh21", 1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 0);
    run_op("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    run_op("lw_oor", 1'b0, 2'd2, 1'b0, 32'(BYTES), 32'h0, 0);
    run_op("illegal", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0);
    run_op("stall", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4);

    // reset pulsed while a store sits in its wait states
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h30; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    chk("rstmid_no_rsp", 32'(n), 32'd0);
    run_op("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = 32'(BYTES) + 32'($urandom_range(0, 15));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, BYTES - 1));
      endcase
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      run_op("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
